ahb_resp_mux: RTL and testbench
===============================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter DW, default 64, the HRDATA width of every slave port and of the master port.
REQ-002 SHALL have port HCLK, input, 1, the single bus clock; all state on the rising edge.
REQ-003 SHALL have port HRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports HSELx0..HSELx8, input, 1 each, address-phase selects from the address decoder; HSELx8 is the reserved/unmapped region.
REQ-005 SHALL have port HTRANS, input, 2, master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 SHALL have port HRDATAS, input, 8*DW, slave read data; slave n occupies bits [n*DW+DW-1 : n*DW].
REQ-007 SHALL have port HREADYOUTS, input, 8, per-slave HREADYOUT; bit n belongs to slave n.
REQ-008 SHALL have port HRESPS, input, 8, per-slave HRESP (0=OKAY, 1=ERROR).
REQ-009 SHALL have port HRDATA, output, DW, read data to the master.
REQ-010 SHALL have port HREADY, output, 1, bus ready to the master and to all slaves.
REQ-011 SHALL have port HRESP, output, 1, response to the master.

Function
REQ-012 SHALL hold a 9-bit data-phase select register sel_q; when HREADY=1 at a rising edge, sel_q SHALL load {HSELx8..HSELx0}; when HREADY=0, sel_q SHALL hold.
REQ-013 SHALL resolve multiple set select bits by lowest index; with no select bit set, it SHALL treat the transfer as a HSELx8 transfer.
REQ-014 SHALL drive HRDATA, HREADY and HRESP combinationally from slave n when sel_q selects n (n=0..7); there is no added latency.
REQ-015 SHALL implement an internal default slave for sel_q bit 8 with states IDLE, ERR1 and ERR2.
REQ-016 In IDLE, the default slave SHALL drive HREADY=1, HRESP=0 and HRDATA=0.
REQ-017 The default slave SHALL move IDLE->ERR1 when HREADY=1, HSELx8=1 and HTRANS[1]=1 at a rising edge.
REQ-018 In ERR1, the default slave SHALL drive HREADY=0 and HRESP=1, then move to ERR2 unconditionally.
REQ-019 In ERR2, the default slave SHALL drive HREADY=1 and HRESP=1; next state SHALL be ERR1 if HSELx8=1 and HTRANS[1]=1, otherwise IDLE.
REQ-020 The default slave SHALL return OKAY with zero wait states for IDLE or BUSY transfers to HSELx8.
REQ-021 While a selected slave holds HREADYOUT=0, new address-phase HSEL values SHALL be ignored.
REQ-022 Back-to-back transfers SHALL switch the source with no bubble cycle (for example, slave 2 data phase followed directly by slave 5 data phase).

Reset
REQ-023 While HRESETn=0, sel_q SHALL select bit 8 and the default slave SHALL be in IDLE, so outputs are HREADY=1, HRESP=0, HRDATA=0.
REQ-024 Reset asserted mid-transfer, including in ERR1 or ERR2, SHALL abort immediately to the reset state; no pending response survives reset.

Configuration
REQ-025 SHALL honour macro AHB_DEFSLV_ERR_EN.
REQ-026 With AHB_DEFSLV_ERR_EN defined, the default slave SHALL behave as in REQ-015..REQ-020.
REQ-027 Without AHB_DEFSLV_ERR_EN, the ERR1/ERR2 states SHALL be absent and every HSELx8 transfer SHALL complete OKAY with zero wait states and HRDATA=0.

Verification
REQ-028 Out of reset: HRESETn low then high, no transfers -> HREADY=1, HRESP=0, HRDATA=0.
REQ-029 NONSEQ to HSELx3 with slave 3 HREADYOUT low for 2 cycles, HRDATAS slice 3=0x1122334455667788 -> HREADY low 2 cycles, then HREADY=1 with HRDATA=0x1122334455667788 and HRESP=0.
REQ-030 NONSEQ to HSELx8 with AHB_DEFSLV_ERR_EN defined -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then IDLE.
REQ-031 Same stimulus without AHB_DEFSLV_ERR_EN -> single cycle HREADY=1, HRESP=0.
REQ-032 Pipelined NONSEQ to HSELx0 then SEQ to HSELx6, both slaves ready -> consecutive data phases return the slice 0 data then the slice 6 data with no gap.
REQ-033 HRESETn pulsed low during ERR1 -> outputs immediately HREADY=1, HRESP=0, and sel_q selects bit 8.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// AHB read-data/response mux with internal default slave for HSELx8.
// Define AHB_DEFSLV_ERR_EN to make the default slave answer with a 2-cycle ERROR.
module ahb_resp_mux #(
  parameter int DW = 64
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELx0,
  input  logic          HSELx1,
  input  logic          HSELx2,
  input  logic          HSELx3,
  input  logic          HSELx4,
  input  logic          HSELx5,
  input  logic          HSELx6,
  input  logic          HSELx7,
  input  logic          HSELx8,
  input  logic [1:0]    HTRANS,
  input  logic [8*DW-1:0] HRDATAS,
  input  logic [7:0]    HREADYOUTS,
  input  logic [7:0]    HRESPS,
  output logic [DW-1:0] HRDATA,
  output logic          HREADY,
  output logic          HRESP
);

  logic [8:0] hsel;
  logic [8:0] sel_nxt;
  logic [8:0] sel_q;
  logic       found;
  logic       def_ready;
  logic       def_resp;
  logic       unused_trans;

  assign hsel = {HSELx8, HSELx7, HSELx6, HSELx5, HSELx4,
                 HSELx3, HSELx2, HSELx1, HSELx0};

  assign unused_trans = ^HTRANS;

  // Lowest index wins; nothing selected falls to the default slave.
  always_comb begin
    sel_nxt = '0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (hsel[i] && !found) begin
        sel_nxt[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!found) sel_nxt[8] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sel_q <= 9'h100;
    else if (HREADY) sel_q <= sel_nxt;
  end

`ifdef AHB_DEFSLV_ERR_EN
  typedef enum logic [1:0] {
    IDLE,
    ERR1,
    ERR2
  } dstate_t;

  dstate_t state;
  logic    err_req;

  assign err_req = sel_nxt[8] & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      def_ready <= 1'b1;
      def_resp  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (HREADY && err_req) begin
            state     <= ERR1;
            def_ready <= 1'b0;
            def_resp  <= 1'b1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          def_ready <= 1'b1;
          def_resp  <= 1'b1;
        end
        ERR2: begin
          if (err_req) begin
            state     <= ERR1;
            def_ready <= 1'b0;
            def_resp  <= 1'b1;
          end else begin
            state     <= IDLE;
            def_ready <= 1'b1;
            def_resp  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          def_ready <= 1'b1;
          def_resp  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign def_ready = 1'b1;
  assign def_resp  = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    HREADY = def_ready;
    HRESP  = def_resp;
    for (int i = 0; i < 8; i++) begin
      if (sel_q[i]) begin
        HRDATA = HRDATAS[i*DW +: DW];
        HREADY = HREADYOUTS[i];
        HRESP  = HRESPS[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux; follows AHB_DEFSLV_ERR_EN if defined.
module tb_ahb_resp_mux;

  localparam int DW = 64;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELx0, HSELx1, HSELx2, HSELx3, HSELx4;
  logic          HSELx5, HSELx6, HSELx7, HSELx8;
  logic [1:0]    HTRANS;
  logic [8*DW-1:0] HRDATAS;
  logic [7:0]    HREADYOUTS;
  logic [7:0]    HRESPS;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] s0, s2, s3, s5, s6;

  ahb_resp_mux #(.DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELx0(HSELx0), .HSELx1(HSELx1), .HSELx2(HSELx2),
    .HSELx3(HSELx3), .HSELx4(HSELx4), .HSELx5(HSELx5),
    .HSELx6(HSELx6), .HSELx7(HSELx7), .HSELx8(HSELx8),
    .HTRANS(HTRANS), .HRDATAS(HRDATAS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus;
    {HSELx8, HSELx7, HSELx6, HSELx5, HSELx4} = '0;
    {HSELx3, HSELx2, HSELx1, HSELx0} = '0;
    HTRANS = T_IDLE;
  endtask

  task automatic test_reset;
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    #2;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", HREADY); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_resp got=%0b exp=0", HRESP); end
    checks++; if (HRDATA !== 64'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", HRDATA); end
    cyc();
    HRESETn = 1'b1;
    cyc();
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL post_rst got=%0b/%0b exp=1/0", HREADY, HRESP); end
    checks++; if (HRDATA !== 64'h0) begin errors++; $display("FAIL post_rst_data got=%h exp=0", HRDATA); end
  endtask

  task automatic test_wait_states;
    cyc();
    HSELx3 = 1'b1; HTRANS = T_NSEQ; HREADYOUTS[3] = 1'b0;
    #3;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL ws_addr got=%0b exp=1", HREADY); end
    cyc();
    HSELx3 = 1'b0; HSELx5 = 1'b1; HTRANS = T_IDLE;
    #3;
    checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL ws_wait1 got=%0b exp=0", HREADY); end
    cyc();
    #3;
    checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL ws_wait2 got=%0b exp=0", HREADY); end
    checks++; if (HRDATA !== s3) begin errors++; $display("FAIL ws_hold_sel got=%h exp=%h", HRDATA, s3); end
    cyc();
    HREADYOUTS[3] = 1'b1; HSELx5 = 1'b0;
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL ws_done got=%0b/%0b exp=1/0", HREADY, HRESP); end
    checks++; if (HRDATA !== 64'h1122334455667788) begin errors++; $display("FAIL ws_data got=%h exp=1122334455667788", HRDATA); end
    cyc();
    #3;
    checks++; if (HRDATA !== 64'h0 || HREADY !== 1'b1) begin errors++; $display("FAIL ws_after got=%h/%0b exp=0/1", HRDATA, HREADY); end
  endtask

  task automatic test_default_slave;
    cyc();
    HSELx8 = 1'b1; HTRANS = T_NSEQ;
    #3;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL ds_addr got=%0b exp=1", HREADY); end
    cyc();
    idle_bus();
    #3;
`ifdef AHB_DEFSLV_ERR_EN
    checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL ds_err1 got=%0b/%0b exp=0/1", HREADY, HRESP); end
    cyc();
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL ds_err2 got=%0b/%0b exp=1/1", HREADY, HRESP); end
`else
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL ds_okay got=%0b/%0b exp=1/0", HREADY, HRESP); end
`endif
    checks++; if (HRDATA !== 64'h0) begin errors++; $display("FAIL ds_data got=%h exp=0", HRDATA); end
    cyc();
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL ds_idle got=%0b/%0b exp=1/0", HREADY, HRESP); end
    HSELx8 = 1'b1; HTRANS = T_IDLE;
    cyc();
    idle_bus();
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL ds_idle_xfer got=%0b/%0b exp=1/0", HREADY, HRESP); end
    HTRANS = T_NSEQ;
    cyc();
    idle_bus();
    #3;
`ifdef AHB_DEFSLV_ERR_EN
    checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL ds_nosel got=%0b/%0b exp=0/1", HREADY, HRESP); end
`else
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL ds_nosel got=%0b/%0b exp=1/0", HREADY, HRESP); end
`endif
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back;
    HSELx0 = 1'b1; HTRANS = T_NSEQ;
    cyc();
    HSELx0 = 1'b0; HSELx6 = 1'b1; HTRANS = T_SEQ;
    #3;
    checks++; if (HREADY !== 1'b1 || HRDATA !== s0) begin errors++; $display("FAIL b2b_s0 got=%h/%0b exp=%h/1", HRDATA, HREADY, s0); end
    cyc();
    idle_bus();
    HSELx2 = 1'b1; HSELx5 = 1'b1; HTRANS = T_NSEQ;
    #3;
    checks++; if (HREADY !== 1'b1 || HRDATA !== s6) begin errors++; $display("FAIL b2b_s6 got=%h/%0b exp=%h/1", HRDATA, HREADY, s6); end
    cyc();
    idle_bus();
    HRESPS[2] = 1'b1;
    #3;
    checks++; if (HRDATA !== s2) begin errors++; $display("FAIL prio got=%h exp=%h", HRDATA, s2); end
    checks++; if (HRESP !== 1'b1) begin errors++; $display("FAIL slv_resp got=%0b exp=1", HRESP); end
    cyc();
    HRESPS[2] = 1'b0;
    #3;
    checks++; if (HRDATA !== 64'h0 || HRESP !== 1'b0) begin errors++; $display("FAIL b2b_end got=%h/%0b exp=0/0", HRDATA, HRESP); end
  endtask

  task automatic test_reset_abort;
    HSELx3 = 1'b1; HTRANS = T_NSEQ; HREADYOUTS[3] = 1'b0;
    cyc();
    idle_bus();
    #3;
    checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL ra_wait got=%0b exp=0", HREADY); end
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0) begin errors++; $display("FAIL ra_slv got=%0b/%0b/%h exp=1/0/0", HREADY, HRESP, HRDATA); end
    #1 HRESETn = 1'b1;
    HREADYOUTS[3] = 1'b1;
`ifdef AHB_DEFSLV_ERR_EN
    cyc();
    HSELx8 = 1'b1; HTRANS = T_NSEQ;
    cyc();
    idle_bus();
    #3;
    checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL ra_err1 got=%0b/%0b exp=0/1", HREADY, HRESP); end
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0) begin errors++; $display("FAIL ra_def got=%0b/%0b/%h exp=1/0/0", HREADY, HRESP, HRDATA); end
    #1 HRESETn = 1'b1;
`endif
    cyc();
    #3;
    checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0) begin errors++; $display("FAIL ra_after got=%0b/%0b/%h exp=1/0/0", HREADY, HRESP, HRDATA); end
  endtask

  initial begin
    idle_bus();
    HREADYOUTS = 8'hFF;
    HRESPS = 8'h00;
    HRDATAS = '0;
    for (int n = 0; n < 8; n++) begin
      HRDATAS[n*DW +: DW] = 64'h0101010101010101 * (n + 1);
    end
    HRDATAS[3*DW +: DW] = 64'h1122334455667788;
    s0 = 64'h0101010101010101;
    s2 = 64'h0303030303030303;
    s3 = 64'h1122334455667788;
    s5 = 64'h0606060606060606;
    s6 = 64'h0707070707070707;
    test_reset();
    test_wait_states();
    test_default_slave();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
